uart_tx_rx: RTL and testbench

UART_TX_RX -- requirements
Module: uart_tx_rx

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx.sv | 138 +++++++++++++
 rtl/uart_tx.sv | 105 ++++++++++
 rtl/uart_tx_rx.sv | 42 ++++
 tb/tb_uart_tx_rx.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver pair: frame state
// encoding, data width, parity mode and the parity helper used by both sides.
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Width of the per-bit clock counter; covers CLKS_PER_BIT up to 65535.
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } parity_mode_t;

  localparam parity_mode_t PARITY_MODE = PAR_EVEN;

  // Parity bit for a data byte: XOR of the bits, inverted for odd mode.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data);
    return (^data) ^ (PARITY_MODE == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: synchronises the asynchronous line, validates the start bit
// at half a bit time, then samples every bit at its centre. Only frames with
// a good stop bit update rx_data/rx_parity_ok; a bad stop bit makes the
// receiver wait for the line to go high again before hunting for a start.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_ok,
  output logic                 rx_done
);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

  logic                 rx_sync_p0;
  logic                 rx_sync_p1;
  logic                 rx_bit;
  uart_state_t          state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par;
  logic                 wait_high;
  logic                 bit_end;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= rx_serial;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  assign rx_bit  = rx_sync_p1;
  assign bit_end = (clk_cnt == BIT_LAST);

  // Sampled data and parity; shifted in LSB first at each bit centre.
  always_ff @(posedge i_clk) begin
    if (state == ST_DATA && bit_end) begin
      rx_shift <= {rx_bit, rx_shift[DATA_BITS-1:1]};
    end
    if (state == ST_PARITY && bit_end) begin
      rx_par <= rx_bit;
    end
  end

  // Frame sequencer with start-bit glitch rejection and stop-bit framing check.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      wait_high    <= 1'b0;
      rx_data      <= '0;
      rx_parity_ok <= 1'b0;
      rx_done      <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (wait_high) begin
            if (rx_bit) begin
              wait_high <= 1'b0;
            end
          end else if (!rx_bit) begin
            // With one cycle per bit the detecting sample is already mid-bit.
            if (HALF_BIT == '0) begin
              state <= ST_DATA;
            end else begin
              state   <= ST_START;
              clk_cnt <= CNT_W'(1);
            end
          end
        end
        ST_START: begin
          if (clk_cnt == HALF_BIT) begin
            clk_cnt <= '0;
            state   <= rx_bit ? ST_IDLE : ST_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == LAST_IDX) begin
              state <= ST_PARITY;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= ST_IDLE;
            if (rx_bit) begin
              rx_data      <= rx_shift;
              rx_parity_ok <= (rx_par == parity_bit(rx_shift));
              rx_done      <= 1'b1;
            end else begin
              wait_high <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          clk_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, parity, stop bit.
// Each bit is held for CLKS_PER_BIT cycles; tx_start is level-sensitive and
// a held request chains frames with one idle cycle between them.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_serial,
  output logic                 tx_done
);

  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

  uart_state_t          state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] tx_byte;
  logic                 bit_end;

  assign bit_end = (clk_cnt == BIT_LAST);

  // Capture the byte when a frame is accepted so later tx_data changes cannot leak in.
  always_ff @(posedge i_clk) begin
    if (state == ST_IDLE && tx_start) begin
      tx_byte <= tx_data;
    end
  end

  // Frame sequencer; tx_serial is registered so each bit starts exactly on an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      tx_serial <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          clk_cnt   <= '0;
          bit_idx   <= '0;
          tx_serial <= 1'b1;
          if (tx_start) begin
            state     <= ST_START;
            tx_serial <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            clk_cnt   <= '0;
            state     <= ST_DATA;
            tx_serial <= tx_byte[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == LAST_IDX) begin
              state     <= ST_PARITY;
              tx_serial <= parity_bit(tx_byte);
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx_serial <= tx_byte[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            clk_cnt   <= '0;
            state     <= ST_STOP;
            tx_serial <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= ST_IDLE;
            tx_done <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          clk_cnt   <= '0;
          tx_serial <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_rx.sv
// UART transmitter and receiver sharing a clock and reset but otherwise
// independent; connecting tx_serial to rx_serial gives a loopback.
module uart_tx_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_serial,
  output logic                 tx_done,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_ok,
  output logic                 rx_done
);

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_serial(tx_serial),
    .tx_done  (tx_done)
  );

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .rx_serial   (rx_serial),
    .rx_data     (rx_data),
    .rx_parity_ok(rx_parity_ok),
    .rx_done     (rx_done)
  );

endmodule

// File: tb/tb_uart_tx_rx.sv
// Directed bench for uart_tx_rx: loopback and chained frames at one cycle per
// bit, hand-built parity/framing fault frames, start-glitch rejection at 16
// cycles per bit, and reset abort of a frame in progress.
module tb_uart_tx_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_serial;
  logic       tx_done;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_parity_ok;
  logic       rx_done;
  logic       loop_en = 1'b1;
  logic       rx_drv = 1'b1;

  logic [7:0] tx_data16 = 8'h00;
  logic       tx_start16 = 1'b0;
  logic       tx_serial16;
  logic       tx_done16;
  logic       rx_drv16 = 1'b1;
  logic [7:0] rx_data16;
  logic       rx_parity_ok16;
  logic       rx_done16;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         tx_q[$];
  logic [7:0] rx_q[$];
  logic       rxp_q[$];
  int         rxc_q[$];
  logic [7:0] rx16_q[$];
  logic       rxp16_q[$];

  // Expected line for 0x0B, index = bit time: start, d0..d7, parity, stop.
  logic [10:0] exp_bits = 11'b11000010110;

  always #5 clk = ~clk;

  assign rx_line = loop_en ? tx_serial : rx_drv;

  uart_tx_rx #(.CLKS_PER_BIT(1)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_serial   (tx_serial),
    .tx_done     (tx_done),
    .rx_serial   (rx_line),
    .rx_data     (rx_data),
    .rx_parity_ok(rx_parity_ok),
    .rx_done     (rx_done)
  );

  uart_tx_rx #(.CLKS_PER_BIT(16)) dut16 (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .tx_data     (tx_data16),
    .tx_start    (tx_start16),
    .tx_serial   (tx_serial16),
    .tx_done     (tx_done16),
    .rx_serial   (rx_drv16),
    .rx_data     (rx_data16),
    .rx_parity_ok(rx_parity_ok16),
    .rx_done     (rx_done16)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record every done pulse with its cycle number.
  always @(negedge clk) begin
    if (tx_done) tx_q.push_back(cyc);
    if (rx_done) begin
      rx_q.push_back(rx_data);
      rxp_q.push_back(rx_parity_ok);
      rxc_q.push_back(cyc);
    end
    if (rx_done16) begin
      rx16_q.push_back(rx_data16);
      rxp16_q.push_back(rx_parity_ok16);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    tx_q.delete();
    rx_q.delete();
    rxp_q.delete();
    rxc_q.delete();
    rx16_q.delete();
    rxp16_q.delete();
  endtask

  // Drive a hand-built frame onto one of the rx inputs; called at a negedge.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int cpb, input bit to16);
    logic [10:0] f;
    f = {stop, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (to16) rx_drv16 = f[i];
      else      rx_drv = f[i];
      repeat (cpb) @(negedge clk);
    end
    if (to16) rx_drv16 = 1'b1;
    else      rx_drv = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_serial", tx_serial, 1'b1);
    chk("rst_tx_done", tx_done, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_parity_ok", rx_parity_ok, 1'b0);
    chk("rst_rx_done", rx_done, 1'b0);
    chk("rst16_tx_serial", tx_serial16, 1'b1);
    chk("rst16_rx_data", rx_data16, 8'h00);

    // Loopback 0x0B with tx_start held, then chained 0xA5 and 0x3C
    clear_q();
    tx_data  = 8'h0B;
    tx_start = 1'b1;
    rst_n    = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k <= 10) chk($sformatf("lb_bit%0d", k), tx_serial, exp_bits[k]);
      if (k == 5) tx_data = 8'h00;
      if (k == 11) begin
        chk("lb_tx_done", tx_done, 1'b1);
        tx_data = 8'hA5;
      end
      if (k == 12) begin
        chk("lb_tx_done_1cyc", tx_done, 1'b0);
        chk("lb_rx_done_early", rx_done, 1'b0);
      end
      if (k == 13) begin
        chk("lb_rx_done", rx_done, 1'b1);
        chk("lb_rx_data", rx_data, 8'h0B);
        chk("lb_rx_parity_ok", rx_parity_ok, 1'b1);
      end
      if (k == 14) tx_data = 8'h3C;
      if (k == 24) tx_start = 1'b0;
    end
    chk("b2b_tx_count", tx_q.size(), 3);
    chk("b2b_rx_count", rx_q.size(), 3);
    if (tx_q.size() >= 3) begin
      chk("b2b_tx_gap1", tx_q[1] - tx_q[0], 12);
      chk("b2b_tx_gap2", tx_q[2] - tx_q[1], 12);
    end
    if (rx_q.size() >= 3) begin
      chk("lb_rx_lag", rxc_q[0] - tx_q[0], 2);
      chk("b2b_rx0", rx_q[0], 8'h0B);
      chk("b2b_rx1", rx_q[1], 8'hA5);
      chk("b2b_rx2", rx_q[2], 8'h3C);
      chk("b2b_par1", rxp_q[1], 1'b1);
      chk("b2b_par2", rxp_q[2], 1'b1);
    end

    // Parity fault: 0x55 has even parity 0, send 1
    loop_en = 1'b0;
    repeat (2) @(negedge clk);
    clear_q();
    send_frame(8'h55, 1'b1, 1'b1, 1, 1'b0);
    repeat (6) @(negedge clk);
    chk("par_rx_count", rx_q.size(), 1);
    if (rx_q.size() >= 1) begin
      chk("par_rx_data", rx_q[0], 8'h55);
      chk("par_rx_parity_ok", rxp_q[0], 1'b0);
    end
    chk("par_hold_data", rx_data, 8'h55);
    chk("par_hold_done", rx_done, 1'b0);

    // Framing fault on 0x12, then a good 0x34
    clear_q();
    send_frame(8'h12, 1'b0, 1'b0, 1, 1'b0);
    repeat (6) @(negedge clk);
    chk("frm_no_done", rx_q.size(), 0);
    chk("frm_keep_data", rx_data, 8'h55);
    send_frame(8'h34, 1'b1, 1'b1, 1, 1'b0);
    repeat (6) @(negedge clk);
    chk("frm_next_count", rx_q.size(), 1);
    chk("frm_next_data", rx_data, 8'h34);
    chk("frm_next_parity_ok", rx_parity_ok, 1'b1);

    // Start glitch at 16 cycles per bit, then a valid frame
    clear_q();
    rx_drv16 = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv16 = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_done", rx16_q.size(), 0);
    chk("glitch_keep_data", rx_data16, 8'h00);
    send_frame(8'hC3, 1'b0, 1'b1, 16, 1'b1);
    repeat (40) @(negedge clk);
    chk("glitch_next_count", rx16_q.size(), 1);
    if (rx16_q.size() >= 1) begin
      chk("glitch_next_data", rx16_q[0], 8'hC3);
      chk("glitch_next_parity_ok", rxp16_q[0], 1'b1);
    end

    // Reset during the data bits of a TX frame
    loop_en = 1'b1;
    repeat (2) @(negedge clk);
    clear_q();
    tx_data  = 8'h0F;
    tx_start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 5) chk("rtx_bit4", tx_serial, 1'b0);
    end
    rst_n    = 1'b0;
    tx_start = 1'b0;
    #1;
    chk("rtx_serial_now", tx_serial, 1'b1);
    repeat (3) @(negedge clk);
    chk("rtx_no_tx_done", tx_q.size(), 0);
    chk("rtx_no_rx_done", rx_q.size(), 0);
    chk("rtx_rx_data_rst", rx_data, 8'h00);
    tx_data  = 8'h81;
    tx_start = 1'b1;
    rst_n    = 1'b1;
    @(negedge clk);
    chk("rtx_restart_bit", tx_serial, 1'b0);
    tx_start = 1'b0;
    repeat (20) @(negedge clk);
    chk("rtx_tx_count", tx_q.size(), 1);
    chk("rtx_rx_count", rx_q.size(), 1);
    chk("rtx_rx_data", rx_data, 8'h81);
    chk("rtx_rx_parity_ok", rx_parity_ok, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
